// File: rtl/uart_rx_msg.sv
// 8N1 serial receiver: two-flop input synchroniser, mid-bit sampling, framing-error
// reporting and a break state that absorbs a line held low after a bad stop bit.
module uart_rx_msg #(
    parameter int CLKS_PER_BIT = 1042
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_serial,
    output logic [7:0] rx_byte,
    output logic       rx_ready,
    output logic       framing_err,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int H  = CLKS_PER_BIT / 2;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state_reg, state_next;
    logic [1:0]    sync_reg;
    logic          rx_s;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [2:0]    idx_reg, idx_next;
    logic [7:0]    sh_reg, sh_next;
    logic [7:0]    byte_reg, byte_next;
    logic          ready_reg, ready_next;
    logic          ferr_reg, ferr_next;
    logic          bit_take;

    // rx_serial is asynchronous; only the second flop is ever looked at.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], rx_serial};
        end
    end

    assign rx_s = sync_reg[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            sh_reg    <= '0;
            byte_reg  <= '0;
            ready_reg <= 1'b0;
            ferr_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            sh_reg    <= sh_next;
            byte_reg  <= byte_next;
            ready_reg <= ready_next;
            ferr_reg  <= ferr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        byte_next  = byte_reg;
        ready_next = 1'b0;
        ferr_next  = 1'b0;
        bit_take   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                cnt_next = '0;
                if (!rx_s) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                if (cnt_reg == CNT_HALF) begin
                    cnt_next = '0;
                    // A start bit that is already high again at mid-bit was a glitch.
                    if (!rx_s) begin
                        state_next = S_DATA;
                        idx_next   = '0;
                    end else begin
                        state_next = S_IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next = '0;
                    bit_take = 1'b1;
                    if (idx_reg == 3'd7) begin
                        state_next = S_STOP;
                    end else begin
                        idx_next = idx_reg + 3'd1;
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            S_STOP: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        byte_next  = sh_reg;
                        ready_next = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = S_BREAK;
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            S_BREAK: begin
                cnt_next = '0;
                if (rx_s) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Each shift-register bit loads only when its own index is being sampled.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_sh
            assign sh_next[gi] = (bit_take && (idx_reg == 3'(gi))) ? rx_s : sh_reg[gi];
        end
    endgenerate

    assign rx_byte     = byte_reg;
    assign rx_ready    = ready_reg;
    assign framing_err = ferr_reg;
    assign busy        = (state_reg != S_IDLE);

endmodule

// File: doc/uart_rx_msg.md
# uart_rx_msg

Serial receiver that consumes the `tx_serial` line driven by the UART transmitter and recovers 8N1 frames into bytes. It sits at the far end of the wireless link, directly downstream of the transmit path. It presents each byte with a one-cycle `rx_ready` strobe to the player-side message logic. Framing errors and start-bit glitches are detected and reported, never delivered as data.

## Interface
- `CLKS_PER_BIT`, default 1042: clock cycles per bit (10 MHz / 9600 baud); must be ≥ 4.
- `clk` input 1: system clock; all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `rx_serial` input 1: asynchronous serial line, idle high, LSB first, 8N1.
- `rx_byte` output 8: last correctly framed byte; holds until the next good frame.
- `rx_ready` output 1: one-cycle pulse; `rx_byte` is valid in that cycle.
- `framing_err` output 1: one-cycle pulse when the stop bit samples low.
- `busy` output 1: high in every state except IDLE.

## Operation
- Input synchroniser: two flops, both reset to 1. `rx_s` is the second flop. All decisions use `rx_s` only.
- Bit counter `cnt` is `$clog2(CLKS_PER_BIT)` bits wide. Bit index `idx` is 3 bits. Shift register `sh` is 8 bits. Define H = CLKS_PER_BIT/2 (floor).
- States and transitions:
  - **IDLE**: `cnt` = 0. If `rx_s` == 0, go to START.
  - **START**: `cnt` increments each cycle. At `cnt` == H-1:
    - if `rx_s` == 0, go to DATA with `cnt` = 0 and `idx` = 0;
    - else go to IDLE (glitch; no output).
  - **DATA**: `cnt` increments. At `cnt` == CLKS_PER_BIT-1:
    - sample `rx_s` into `sh[idx]` and set `cnt` = 0;
    - if `idx` == 7, go to STOP; else `idx` += 1.
  - **STOP**: at `cnt` == CLKS_PER_BIT-1, sample `rx_s`:
    - if 1, load `rx_byte` <= `sh`, pulse `rx_ready`, go to IDLE;
    - if 0, pulse `framing_err`, leave `rx_byte` unchanged, go to BREAK.
  - **BREAK**: wait until `rx_s` == 1, then go to IDLE. A line held low never produces repeated frames or errors.
- `rx_ready` and `framing_err` are registered and mutually exclusive.
- No back-pressure. The consumer must take `rx_byte` during `rx_ready` or before the next good frame completes.
- Reset mid-frame abandons the frame. No pulse is produced for the abandoned frame.

## Timing
- Reset values:
  - `rx_byte` = 8'h00
  - `rx_ready` = 0
  - `framing_err` = 0
  - `busy` = 0
  - state = IDLE
  - `cnt`, `idx`, `sh` = 0
  - synchroniser flops = 1
- Synchroniser latency: 2 cycles from `rx_serial` to `rx_s`.
- Let edge E be the first rising edge at which `rx_s` == 0 in IDLE.
  - The start sample is taken H cycles after E.
  - Data bit k is sampled (k+1)·CLKS_PER_BIT cycles after the start sample.
  - The stop sample is taken 9·CLKS_PER_BIT cycles after the start sample.
  - `rx_ready` or `framing_err` is high in the cycle immediately after the stop-sample edge.
- `busy` rises the cycle after E. It falls together with the `rx_ready` pulse, or on leaving BREAK.
- Back-to-back frames:
  - A start bit beginning right after the stop bit is accepted, because the state is IDLE at the mid-stop point.
  - Minimum idle between frames is 0 bit times beyond a full stop bit.
- Glitch rejection: a low pulse on `rx_s` shorter than H cycles returns the block to IDLE silently.

## Test plan
Bench overrides CLKS_PER_BIT = 8 (H = 4). The driver sends ideal 8-cycle bits.
- **Reset:** hold `rst` for 3 cycles while `rx_serial` toggles. Required: all outputs at reset values, `busy` = 0 throughout.
- **Single frame 8'hA5:**
  - required: exactly one `rx_ready` pulse with `rx_byte` = 8'hA5 and `framing_err` never asserted;
  - required timing: pulse at E + 4 + 72 + 1 cycles.
- **Back-to-back frames 8'h00, 8'hFF, 8'h3C with no idle gap:** required: three `rx_ready` pulses in order with matching bytes, spaced exactly 80 cycles apart.
- **Framing error:** send 8'h55 with the stop bit low, then hold the line low for 40 cycles, then release it high. Required:
  - one `framing_err` pulse and no `rx_ready`;
  - `rx_byte` keeps its prior value;
  - `busy` stays high until 2 cycles after release;
  - a following good frame 8'h12 is received correctly.
- **Glitch:** a 3-cycle low pulse on `rx_serial` while idle. Required: no pulses, and `busy` returns to 0 within 6 cycles. A subsequent 8'h81 frame is received correctly.
- **Reset mid-frame:** assert `rst` during data bit 4 of 8'hC3. Required: no pulse for that frame. A following 8'h7E frame is received correctly.
